// File: rtl/note_tone_if.sv
// -----------------------------------------------------------------------------
// note_tone_if
// Purpose : groups the frequency handshake, note gate and audio sample signals
//           between a note controller (master) and note_tone_gen (slave).
// Signals :
//   freq_in     [15:0]        frequency in hundredths of Hz, 0 = silence
//   freq_valid                freq_in valid
//   freq_ready                generator can accept a new frequency
//   note_on                   gate: 1 = tone sounding, 0 = muted
//   sample      [SAMPLE_W-1:0] signed square-wave sample (two's complement)
//   tone_active               output currently non-silent
// Handshake : a frequency transfers on a rising clk edge where freq_valid and
//             freq_ready are both 1. freq_valid while freq_ready is 0 is
//             dropped, not held. The master may change freq_in after transfer.
// -----------------------------------------------------------------------------
interface note_tone_if #(
   parameter int SAMPLE_W = 24
) ();
   logic [15:0]                freq_in;
   logic                       freq_valid;
   logic                       freq_ready;
   logic                       note_on;
   logic signed [SAMPLE_W-1:0] sample;
   logic                       tone_active;

   modport master (
      output freq_in, freq_valid, note_on,
      input  freq_ready, sample, tone_active
   );

   modport slave (
      input  freq_in, freq_valid, note_on,
      output freq_ready, sample, tone_active
   );
endinterface

// File: rtl/note_tone_gen.sv
// -----------------------------------------------------------------------------
// note_tone_gen
// Purpose : turns a 16-bit frequency (hundredths of Hz) into a signed square
//           wave. half_period = floor(CLK_FREQ*50 / freq) is found by a 32-step
//           restoring divider; a period counter toggles the output level every
//           half_period clocks.
// Ports   :
//   clk                clock, rising edge
//   resetn             synchronous reset, active low
//   tone_if            note_tone_if.slave (frequency handshake, gate, sample)
//   o_dbg_state [1:0]  FSM state (0 IDLE, 1 DIV, 2 LOAD)
//   o_dbg_half_period  currently active half-period in clocks
// Config  : define TONE_ENVELOPE_EN for a linear attack/release envelope;
//           without it the gate is instantaneous and ENV_* are unused.
// -----------------------------------------------------------------------------
module note_tone_gen #(
   parameter int                   CLK_FREQ  = 50_000_000,
   parameter int                   SAMPLE_W  = 24,
   parameter logic [SAMPLE_W-1:0]  AMPLITUDE = 24'h200000,
   parameter logic [SAMPLE_W-1:0]  ENV_STEP  = 24'h000100,
   parameter int                   ENV_DIV   = 1000
) (
   input  logic        clk,
   input  logic        resetn,
   note_tone_if.slave  tone_if,
   output logic [1:0]  o_dbg_state,
   output logic [31:0] o_dbg_half_period
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_LOAD = 2'd2} state_t;

   // CLK_FREQ*50 overflows a 32-bit int, so form it in 64 bits first
   localparam logic [63:0] NUMER_W = 64'(CLK_FREQ) * 64'd50;
   localparam logic [31:0] NUMER   = NUMER_W[31:0];

   state_t              r_state, w_state_nxt;
   logic [4:0]          r_bit_cnt;
   logic [15:0]         r_div;
   logic [32:0]         r_rem;
   logic [31:0]         r_quo;
   logic [31:0]         r_hp, w_hp_nxt;
   logic [31:0]         r_cnt, w_cnt_nxt;
   logic                r_level, w_level_nxt;
   logic [SAMPLE_W-1:0] r_sample;
   logic                r_active;

   logic                w_accept, w_start;
   logic [32:0]         w_shift, w_sub;
   logic                w_ge;
   logic [SAMPLE_W-1:0] w_mag;
   logic                w_gate;

   assign w_accept = tone_if.freq_valid && (r_state == S_IDLE);
   assign w_start  = w_accept && (tone_if.freq_in != 16'd0);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_DIV;
         S_DIV:   if (r_bit_cnt == 5'd31) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- restoring divider ----------------
   // r_quo starts as the numerator; each step shifts its MSB into the partial
   // remainder and shifts the new quotient bit in at the LSB.
   assign w_shift = {r_rem[31:0], r_quo[31]};
   assign w_ge    = (w_shift >= {17'd0, r_div});
   assign w_sub   = w_shift - {17'd0, r_div};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_bit_cnt <= '0;
         r_div     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_start) begin
            r_div     <= tone_if.freq_in;
            r_rem     <= '0;
            r_quo     <= NUMER;
            r_bit_cnt <= '0;
         end
      end else if (r_state == S_DIV) begin
         r_rem     <= w_ge ? w_sub : w_shift;
         r_quo     <= {r_quo[30:0], w_ge};
         r_bit_cnt <= r_bit_cnt + 5'd1;
      end
   end

   // ---------------- period counter ----------------
   always_comb begin
      w_hp_nxt    = r_hp;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      if (r_state == S_LOAD) begin
         // new pitch starts a fresh half-period, keeping the current polarity
         w_hp_nxt  = r_quo;
         w_cnt_nxt = '0;
      end else if (w_accept && !w_start) begin
         w_hp_nxt  = '0;
         w_cnt_nxt = '0;
      end else if (r_hp != 32'd0) begin
         if (r_cnt == r_hp - 32'd1) begin
            w_cnt_nxt   = '0;
            w_level_nxt = ~r_level;
         end else begin
            w_cnt_nxt = r_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hp    <= '0;
         r_cnt   <= '0;
         r_level <= 1'b1;
      end else begin
         r_hp    <= w_hp_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
      end
   end

   // ---------------- amplitude / gate ----------------
`ifdef TONE_ENVELOPE_EN
   localparam logic [31:0] ENV_LAST = 32'(ENV_DIV - 1);

   logic [31:0]         r_presc;
   logic [SAMPLE_W-1:0] r_env, w_env_nxt;

   always_comb begin
      w_env_nxt = r_env;
      if (r_presc == ENV_LAST) begin
         if (tone_if.note_on)
            w_env_nxt = (r_env >= AMPLITUDE - ENV_STEP) ? AMPLITUDE : r_env + ENV_STEP;
         else
            w_env_nxt = (r_env <= ENV_STEP) ? '0 : r_env - ENV_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_presc <= '0;
         r_env   <= '0;
      end else begin
         r_presc <= (r_presc == ENV_LAST) ? 32'd0 : r_presc + 32'd1;
         r_env   <= w_env_nxt;
      end
   end

   // the envelope itself does the gating; a zero envelope is silence
   assign w_mag  = w_env_nxt;
   assign w_gate = 1'b1;

   logic w_unused_rem;
   assign w_unused_rem = r_rem[32];
`else
   assign w_mag  = AMPLITUDE;
   assign w_gate = tone_if.note_on;

   // remainder bit 32 never sets (remainder < divisor < 2^16); ENV_* unused here
   logic w_unused_env;
   assign w_unused_env = ^{r_rem[32], ENV_STEP, ENV_DIV};
`endif

   // sample is built from next-state values so it lines up with the
   // half_period/level change on the same edge
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_sample <= '0;
         r_active <= 1'b0;
      end else begin
         r_sample <= (w_gate && w_hp_nxt != 32'd0) ? (w_level_nxt ? w_mag : -w_mag) : '0;
         r_active <= w_gate && (w_mag != '0) && (w_hp_nxt != 32'd0);
      end
   end

   assign tone_if.freq_ready  = (r_state == S_IDLE);
   assign tone_if.sample      = r_sample;
   assign tone_if.tone_active = r_active;
   assign o_dbg_state         = r_state;
   assign o_dbg_half_period   = r_hp;

endmodule

// File: tb/tb_note_tone_gen.sv
module tb_note_tone_gen;
   localparam int SW = 24;
   localparam logic [SW-1:0] AP = 24'h200000;  // +AMPLITUDE
   localparam logic [SW-1:0] AN = 24'hE00000;  // -AMPLITUDE
   localparam logic [3:0] M_ALL = 4'b1111;     // mask bits: 0 sample, 1 active, 2 ready, 3 half_period
   localparam logic [3:0] M_RDY = 4'b0100;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   note_tone_if #(.SAMPLE_W(SW)) tif ();
   logic [1:0]  dbg_state;
   logic [31:0] dbg_hp;

   note_tone_gen #(.SAMPLE_W(SW)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .tone_if           (tif),
      .o_dbg_state       (dbg_state),
      .o_dbg_half_period (dbg_hp)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      int          id;
      logic [3:0]  mask;
      logic [SW-1:0] smp;
      logic        act;
      logic        rdy;
      logic [31:0] hp;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic push(input int id, input logic [3:0] mask, input logic [SW-1:0] smp,
                       input logic act, input logic rdy, input logic [31:0] hp);
      exp_t e;
      e.id = id; e.mask = mask; e.smp = smp; e.act = act; e.rdy = rdy; e.hp = hp;
      exp_q.push_back(e);
   endtask

   // monitor: compares one queued expectation per falling edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.mask[0]) begin
            checks++;
            if (tif.sample !== e.smp) begin
               errors++;
               $display("FAIL chk%0d sample: got %h expected %h", e.id, tif.sample, e.smp);
            end
         end
         if (e.mask[1]) begin
            checks++;
            if (tif.tone_active !== e.act) begin
               errors++;
               $display("FAIL chk%0d tone_active: got %b expected %b", e.id, tif.tone_active, e.act);
            end
         end
         if (e.mask[2]) begin
            checks++;
            if (tif.freq_ready !== e.rdy) begin
               errors++;
               $display("FAIL chk%0d freq_ready: got %b expected %b", e.id, tif.freq_ready, e.rdy);
            end
         end
         if (e.mask[3]) begin
            checks++;
            if (dbg_hp !== e.hp) begin
               errors++;
               $display("FAIL chk%0d half_period: got %0d expected %0d", e.id, dbg_hp, e.hp);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // returns 1 ns after the accepting edge
   task automatic req(input logic [15:0] f);
      tif.freq_in    = f;
      tif.freq_valid = 1'b1;
      tick();
      tif.freq_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tif.freq_in    = 16'd0;
      tif.freq_valid = 1'b0;
      tif.note_on    = 1'b0;

      // reset held 3 cycles, then idle with no stimulus
      resetn = 1'b0;
      ticks(3);
      push(1, M_ALL, '0, 1'b0, 1'b1, 32'd0);
      resetn = 1'b1;
      ticks(5);
      push(2, M_ALL, '0, 1'b0, 1'b1, 32'd0);

      // 440.00 Hz: half_period = 2_500_000_000 / 44000 = 56818
      tif.note_on = 1'b1;
      req(16'd44000);
      push(3, M_ALL, '0, 1'b0, 1'b0, 32'd0);
      ticks(32);
      push(4, M_ALL, '0, 1'b0, 1'b0, 32'd0);
      tick();
      push(5, M_ALL, AP, 1'b1, 1'b1, 32'd56818);
      ticks(56817);
      push(6, M_ALL, AP, 1'b1, 1'b1, 32'd56818);
      tick();
      push(7, M_ALL, AN, 1'b1, 1'b1, 32'd56818);
      tif.note_on = 1'b0;
      tick();
      push(8, M_ALL, '0, 1'b0, 1'b1, 32'd56818);
      tif.note_on = 1'b1;
      tick();
      push(9, M_ALL, AN, 1'b1, 1'b1, 32'd56818);

      // 16.35 Hz: 2_500_000_000 / 1635 = 1529051; old tone plays during divide
      req(16'd1635);
      push(10, M_RDY, '0, 1'b0, 1'b0, 32'd0);
      ticks(10);
      push(11, M_ALL, AN, 1'b1, 1'b0, 32'd56818);
      ticks(22);
      push(12, M_ALL, AN, 1'b1, 1'b0, 32'd56818);
      tick();
      push(13, M_ALL, AN, 1'b1, 1'b1, 32'd1529051);

      // 655.35 Hz: 38147; a 9800 request while busy must be dropped
      req(16'd65535);
      ticks(5);
      tif.freq_in    = 16'd9800;
      tif.freq_valid = 1'b1;
      tick();
      tif.freq_valid = 1'b0;
      push(14, M_RDY, '0, 1'b0, 1'b0, 32'd0);
      ticks(26);
      push(15, M_ALL, AN, 1'b1, 1'b0, 32'd1529051);
      tick();
      push(16, M_ALL, AN, 1'b1, 1'b1, 32'd38147);
      ticks(7);
      push(17, M_ALL, AN, 1'b1, 1'b1, 32'd38147);

      // frequency 0: immediate silence, stays ready
      req(16'd0);
      push(18, M_ALL, '0, 1'b0, 1'b1, 32'd0);
      ticks(3);
      push(19, M_ALL, '0, 1'b0, 1'b1, 32'd0);

      // reset in the middle of a divide: no partial result appears
      req(16'd44000);
      ticks(10);
      resetn = 1'b0;
      tick();
      push(20, M_ALL, '0, 1'b0, 1'b1, 32'd0);
      resetn = 1'b1;
      ticks(40);
      push(21, M_ALL, '0, 1'b0, 1'b1, 32'd0);

      ticks(3);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, expected stimulus to complete");
      $fatal(1, "watchdog");
   end

endmodule
